interrupt_acknowledge_initiator: RTL and testbench
==================================================

Name: interrupt_acknowledge_initiator

Overview:
- CPU-side counterpart of the 8259A control logic.
- When INT is raised and the CPU accepts interrupts, the block drives the interrupt_acknowledge_n pulse train:
  - 2 pulses in 8086 mode.
  - 3 pulses in MCS-80 mode.
- It samples the 8259A data bus during each pulse, assembles the vector or CALL address, and presents it to the CPU core with a valid/accept handshake.
- It serves as the bench-side and system-side driver of the PIC acknowledge protocol.

Parameters:
- PULSE_LOW_CYCLES, 4, clock cycles interrupt_acknowledge_n is held low per pulse (legal range 1..15).
- PULSE_HIGH_CYCLES, 2, clock cycles interrupt_acknowledge_n is held high between pulses (legal range 1..15).
- CALL_OPCODE, 8'hCD, expected first byte in MCS-80 mode.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- interrupt_to_cpu  input  1  INT from the 8259A; level.
- interrupt_enable  input  1  CPU interrupt-enable flag; 1 = requests may start a sequence.
- u8086_mode  input  1  1 = 8086 (2 pulses), 0 = MCS-80 (3 pulses); latched at sequence start.
- data_bus_in  input  8  8259A data bus as seen by the CPU.
- interrupt_acknowledge_n  output  1  INTA# to the 8259A; registered, active low.
- busy  output  1  sequence in progress (any state except IDLE).
- vector_valid  output  1  captured result available.
- vector_accept  input  1  CPU consumes the result; effective only while vector_valid=1.
- vector_type  output  8  8086 interrupt type (byte from pulse 2).
- call_opcode  output  8  MCS-80 byte from pulse 1.
- call_address  output  16  MCS-80 address, {byte pulse 3, byte pulse 2}.
- opcode_error  output  1  MCS-80 pulse-1 byte differed from CALL_OPCODE; valid with vector_valid.

Behaviour:
- Reset (reset_n=0 at a clock edge) forces the following values on the next cycle, regardless of state or mid-pulse position:
  - state IDLE
  - interrupt_acknowledge_n=1, busy=0, vector_valid=0, opcode_error=0
  - vector_type=0, call_opcode=0, call_address=0
  - counters=0
- States:
  - IDLE
  - PULSE_LOW: interrupt_acknowledge_n=0.
  - PULSE_HIGH: inter-pulse gap, interrupt_acknowledge_n=1.
  - DONE: holds result, interrupt_acknowledge_n=1.
- IDLE -> PULSE_LOW when interrupt_to_cpu=1 and interrupt_enable=1 at edge T.
  - interrupt_acknowledge_n is low from cycle T+1.
  - u8086_mode is latched at T.
  - The pulse index clears to 0.
  - Previous result registers are cleared at T.
- PULSE_LOW lasts exactly PULSE_LOW_CYCLES cycles.
  - data_bus_in is sampled on the last low cycle into the byte slot for the current pulse index.
  - 8086 mode:
    - pulse 0 byte is discarded (bus floating).
    - pulse 1 byte goes to vector_type.
  - MCS-80 mode:
    - pulse 0 goes to call_opcode, and opcode_error is set if it differs from CALL_OPCODE.
    - pulse 1 goes to call_address[7:0].
    - pulse 2 goes to call_address[15:8].
- After PULSE_LOW:
  - If it was not the final pulse (index < 1 for 8086, index < 2 for MCS-80): PULSE_HIGH for PULSE_HIGH_CYCLES cycles, then PULSE_LOW with index+1.
  - If it was the final pulse: DONE. interrupt_acknowledge_n returns high and vector_valid=1 in the same first DONE cycle.
- DONE:
  - Outputs are held stable.
  - On the cycle vector_valid=1 and vector_accept=1, go to IDLE. vector_valid=0 on the next cycle.
  - A new sequence may start on the first IDLE cycle.
  - Minimum interrupt_acknowledge_n high time between sequences is 2 cycles.
- interrupt_to_cpu or interrupt_enable dropping mid-sequence is ignored; the sequence always completes (the 8259A supplies the spurious vector).
- vector_accept is ignored outside DONE.
- Total latency from the request edge T to vector_valid:
  - 8086: T+2·LOW+HIGH+1.
  - MCS-80: T+3·LOW+2·HIGH+1.
- Pulse and gap counters are 4-bit, with no wrap within legal parameter ranges.

Test Plan:
- 8086 mode, defaults: interrupt_to_cpu=1 at cycle 0, data_bus_in=0x48 during pulse 2.
  - interrupt_acknowledge_n low on cycles 1–4 and 7–10, high on 5–6.
  - vector_valid=1 at cycle 11 with vector_type=0x48.
  - busy=1 on cycles 1–11.
- MCS-80 mode: bytes 0xCD, 0x20, 0x01 on pulses 1–3.
  - Pulses low on cycles 1–4, 7–10 and 13–16.
  - vector_valid at cycle 17 with call_opcode=0xCD, call_address=0x0120, opcode_error=0.
- MCS-80 mode, pulse-1 byte 0x00 -> opcode_error=1 together with vector_valid; address still captured.
- interrupt_enable=0 with interrupt_to_cpu=1 for 20 cycles -> interrupt_acknowledge_n stays 1 and busy=0.
  - Raising interrupt_enable at cycle 20 -> first low at cycle 21.
- Backpressure: vector_accept held 0 for 5 cycles after vector_valid while interrupt_to_cpu stays 1.
  - No new pulse and outputs stable until accepted.
  - Accept at cycle A -> vector_valid=0 at A+1, next pulse low at A+2.
- reset_n=0 for one cycle during pulse 2 of an 8086 sequence -> next cycle interrupt_acknowledge_n=1, busy=0, vector_valid=0, vector_type=0.
  - With interrupt_to_cpu still high, a new sequence starts the following cycle.

Source files
------------

// File: rtl/interrupt_acknowledge_initiator.sv
// CPU-side driver of the 8259A interrupt acknowledge protocol. Generates the
// INTA# pulse train (2 pulses in 8086 mode, 3 in MCS-80 mode), samples the PIC
// data bus on the last low cycle of each pulse, and hands the assembled vector
// or CALL address to the CPU core through a valid/accept handshake.
module interrupt_acknowledge_initiator #(
  parameter int unsigned PULSE_LOW_CYCLES  = 4,
  parameter int unsigned PULSE_HIGH_CYCLES = 2,
  parameter logic [7:0]  CALL_OPCODE       = 8'hCD
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        interrupt_to_cpu,
  input  logic        interrupt_enable,
  input  logic        u8086_mode,
  input  logic [7:0]  data_bus_in,
  output logic        interrupt_acknowledge_n,
  output logic        busy,
  output logic        vector_valid,
  input  logic        vector_accept,
  output logic [7:0]  vector_type,
  output logic [7:0]  call_opcode,
  output logic [15:0] call_address,
  output logic        opcode_error
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 2;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PULSE_LOW  = 2'd1;
  localparam logic [1:0] ST_PULSE_HIGH = 2'd2;
  localparam logic [1:0] ST_DONE       = 2'd3;

  // Terminal counts: the counter runs 0..N-1 inside each phase.
  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(PULSE_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(PULSE_HIGH_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mode_q, mode_d;
  logic             inta_n_q, inta_n_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [7:0]       vector_type_q, vector_type_d;
  logic [7:0]       call_opcode_q, call_opcode_d;
  logic [15:0]      call_address_q, call_address_d;
  logic             opcode_error_q, opcode_error_d;

  logic             last_pulse;

  // Final pulse index depends on the mode latched at sequence start.
  always_comb begin
    last_pulse = mode_q ? (idx_q == IDX_W'(1)) : (idx_q == IDX_W'(2));
  end

  // Next-state, counter, capture and output computation.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    mode_d         = mode_q;
    inta_n_d       = inta_n_q;
    valid_d        = valid_q;
    vector_type_d  = vector_type_q;
    call_opcode_d  = call_opcode_q;
    call_address_d = call_address_q;
    opcode_error_d = opcode_error_q;

    case (state_q)
      ST_IDLE: begin
        if (interrupt_to_cpu && interrupt_enable) begin
          state_d        = ST_PULSE_LOW;
          inta_n_d       = 1'b0;
          cnt_d          = '0;
          idx_d          = '0;
          mode_d         = u8086_mode;
          valid_d        = 1'b0;
          vector_type_d  = '0;
          call_opcode_d  = '0;
          call_address_d = '0;
          opcode_error_d = 1'b0;
        end
      end

      ST_PULSE_LOW: begin
        if (cnt_q == LOW_LAST) begin
          // Last low cycle: the PIC is driving the byte for this pulse.
          if (mode_q) begin
            // 8086: pulse 0 bus is floating and is dropped.
            if (idx_q == IDX_W'(1)) begin
              vector_type_d = data_bus_in;
            end
          end else begin
            case (idx_q)
              IDX_W'(0): begin
                call_opcode_d  = data_bus_in;
                opcode_error_d = (data_bus_in != CALL_OPCODE);
              end
              IDX_W'(1): call_address_d[7:0]  = data_bus_in;
              IDX_W'(2): call_address_d[15:8] = data_bus_in;
              default:   ;
            endcase
          end
          cnt_d    = '0;
          inta_n_d = 1'b1;
          if (last_pulse) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
          end else begin
            state_d = ST_PULSE_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_PULSE_HIGH: begin
        if (cnt_q == HIGH_LAST) begin
          state_d  = ST_PULSE_LOW;
          inta_n_d = 1'b0;
          cnt_d    = '0;
          idx_d    = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        // Result held until the core takes it.
        if (valid_q && vector_accept) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        inta_n_d = 1'b1;
        valid_d  = 1'b0;
        cnt_d    = '0;
        idx_d    = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      mode_q         <= 1'b0;
      inta_n_q       <= 1'b1;
      busy_q         <= 1'b0;
      valid_q        <= 1'b0;
      vector_type_q  <= '0;
      call_opcode_q  <= '0;
      call_address_q <= '0;
      opcode_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      mode_q         <= mode_d;
      inta_n_q       <= inta_n_d;
      busy_q         <= busy_d;
      valid_q        <= valid_d;
      vector_type_q  <= vector_type_d;
      call_opcode_q  <= call_opcode_d;
      call_address_q <= call_address_d;
      opcode_error_q <= opcode_error_d;
    end
  end

  assign interrupt_acknowledge_n = inta_n_q;
  assign busy                    = busy_q;
  assign vector_valid            = valid_q;
  assign vector_type             = vector_type_q;
  assign call_opcode             = call_opcode_q;
  assign call_address            = call_address_q;
  assign opcode_error            = opcode_error_q;

endmodule

// File: tb/tb_interrupt_acknowledge_initiator.sv
// Directed bench for interrupt_acknowledge_initiator with default parameters
// (LOW=4, HIGH=2, CALL_OPCODE=0xCD). Cycle k is the interval after edge k-1;
// inputs driven in cycle k are sampled at the edge closing it.
module tb_interrupt_acknowledge_initiator;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        interrupt_to_cpu;
  logic        interrupt_enable;
  logic        u8086_mode;
  logic [7:0]  data_bus_in;
  logic        interrupt_acknowledge_n;
  logic        busy;
  logic        vector_valid;
  logic        vector_accept;
  logic [7:0]  vector_type;
  logic [7:0]  call_opcode;
  logic [15:0] call_address;
  logic        opcode_error;

  int n_checks = 0;
  int n_fail   = 0;

  interrupt_acknowledge_initiator dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .interrupt_to_cpu        (interrupt_to_cpu),
    .interrupt_enable        (interrupt_enable),
    .u8086_mode              (u8086_mode),
    .data_bus_in             (data_bus_in),
    .interrupt_acknowledge_n (interrupt_acknowledge_n),
    .busy                    (busy),
    .vector_valid            (vector_valid),
    .vector_accept           (vector_accept),
    .vector_type             (vector_type),
    .call_opcode             (call_opcode),
    .call_address            (call_address),
    .opcode_error            (opcode_error)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Starts a sequence from an IDLE cycle (cycle 0) and stops in the first DONE
  // cycle. Pulse p is low on cycles 6p+1..6p+4; byte b[p] is on the bus then.
  task automatic run_seq(input logic mode, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic keep_int,
                         input logic [7:0] exp_type, input logic [7:0] exp_op,
                         input logic [15:0] exp_addr, input logic exp_err);
    logic [7:0] bytes [3];
    int last_low;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    last_low = mode ? 10 : 16;
    interrupt_to_cpu = 1'b1;
    interrupt_enable = 1'b1;
    u8086_mode       = mode;
    data_bus_in      = 8'hFF;
    for (int k = 1; k <= last_low; k++) begin
      tick();
      check_eq($sformatf("inta_n c%0d", k), 32'(interrupt_acknowledge_n),
               32'(((k - 1) % 6) >= 4));
      check_eq($sformatf("busy c%0d", k), 32'(busy), 32'd1);
      check_eq($sformatf("valid c%0d", k), 32'(vector_valid), 32'd0);
      data_bus_in = bytes[(k - 1) / 6];
      if (k == 1) begin
        // Mode is latched at start and request changes mid-sequence are ignored.
        u8086_mode = ~mode;
        if (!keep_int) begin
          interrupt_to_cpu = 1'b0;
          interrupt_enable = 1'b0;
        end
      end
    end
    tick();
    data_bus_in = 8'hFF;
    check_eq("done valid", 32'(vector_valid), 32'd1);
    check_eq("done inta_n", 32'(interrupt_acknowledge_n), 32'd1);
    check_eq("done busy", 32'(busy), 32'd1);
    check_eq("vector_type", 32'(vector_type), 32'(exp_type));
    check_eq("call_opcode", 32'(call_opcode), 32'(exp_op));
    check_eq("call_address", 32'(call_address), 32'(exp_addr));
    check_eq("opcode_error", 32'(opcode_error), 32'(exp_err));
  endtask

  task automatic accept_result();
    vector_accept = 1'b1;
    tick();
    vector_accept = 1'b0;
    check_eq("accept valid", 32'(vector_valid), 32'd0);
    check_eq("accept busy", 32'(busy), 32'd0);
    check_eq("accept inta_n", 32'(interrupt_acknowledge_n), 32'd1);
  endtask

  initial begin
    reset_n          = 1'b0;
    interrupt_to_cpu = 1'b0;
    interrupt_enable = 1'b0;
    u8086_mode       = 1'b0;
    data_bus_in      = 8'h00;
    vector_accept    = 1'b0;
    tick();
    tick();

    // Reset values.
    check_eq("rst inta_n", 32'(interrupt_acknowledge_n), 32'd1);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst valid", 32'(vector_valid), 32'd0);
    check_eq("rst vector_type", 32'(vector_type), 32'd0);
    check_eq("rst call_opcode", 32'(call_opcode), 32'd0);
    check_eq("rst call_address", 32'(call_address), 32'd0);
    check_eq("rst opcode_error", 32'(opcode_error), 32'd0);
    reset_n = 1'b1;
    tick();

    // 8086 sequence; INT stays high to exercise backpressure afterwards.
    run_seq(1'b1, 8'hFF, 8'h48, 8'hFF, 1'b1, 8'h48, 8'h00, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp valid", 32'(vector_valid), 32'd1);
      check_eq("bp inta_n", 32'(interrupt_acknowledge_n), 32'd1);
      check_eq("bp vector_type", 32'(vector_type), 32'h48);
    end
    accept_result();
    tick();
    check_eq("restart inta_n", 32'(interrupt_acknowledge_n), 32'd0);
    check_eq("restart busy", 32'(busy), 32'd1);
    check_eq("restart cleared type", 32'(vector_type), 32'd0);

    // Reset during pulse 2 (relative cycle 8) of the restarted 8086 sequence.
    for (int k = 2; k <= 8; k++) tick();
    check_eq("pre-rst inta_n", 32'(interrupt_acknowledge_n), 32'd0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_eq("midrst inta_n", 32'(interrupt_acknowledge_n), 32'd1);
    check_eq("midrst busy", 32'(busy), 32'd0);
    check_eq("midrst valid", 32'(vector_valid), 32'd0);
    check_eq("midrst vector_type", 32'(vector_type), 32'd0);
    tick();
    check_eq("post-rst start inta_n", 32'(interrupt_acknowledge_n), 32'd0);
    check_eq("post-rst start busy", 32'(busy), 32'd1);
    interrupt_to_cpu = 1'b0;
    interrupt_enable = 1'b0;
    do_reset();

    // MCS-80 with a proper CALL opcode.
    run_seq(1'b0, 8'hCD, 8'h20, 8'h01, 1'b0, 8'h00, 8'hCD, 16'h0120, 1'b0);
    accept_result();

    // MCS-80 with a bad first byte: flagged, address still captured.
    run_seq(1'b0, 8'h00, 8'h34, 8'h12, 1'b0, 8'h00, 8'h00, 16'h1234, 1'b1);
    accept_result();

    // Requests blocked while interrupts are disabled.
    interrupt_to_cpu = 1'b1;
    interrupt_enable = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_eq($sformatf("dis inta_n c%0d", k), 32'(interrupt_acknowledge_n), 32'd1);
      check_eq($sformatf("dis busy c%0d", k), 32'(busy), 32'd0);
    end
    interrupt_enable = 1'b1;
    tick();
    check_eq("enable inta_n", 32'(interrupt_acknowledge_n), 32'd0);
    check_eq("enable busy", 32'(busy), 32'd1);
    interrupt_to_cpu = 1'b0;
    interrupt_enable = 1'b0;
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
